// File: rtl/rx_eq_pkg.sv
// rtl/rx_eq_pkg.sv - shared constants, state encoding and saturation helpers for the Rx LMS equalizer
package rx_eq_pkg;

  localparam int H         = 7;
  localparam int W         = 9;
  localparam int DATA_F    = 7;
  localparam int CW        = 12;
  localparam int COEF_F    = 10;
  localparam int CENTER    = 3;
  localparam int MU_SHIFT  = 4;
  localparam int TRAIN_LEN = 512;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int ACC_W     = W + CW + clog2(H) + 1;
  localparam int UPD_SHIFT = 2 * DATA_F - COEF_F + MU_SHIFT;
  localparam int CNT_W     = clog2(TRAIN_LEN);

  localparam int W_MAX  = (1 << (W - 1)) - 1;
  localparam int W_MIN  = -(1 << (W - 1));
  localparam int CW_MAX = (1 << (CW - 1)) - 1;
  localparam int CW_MIN = -(1 << (CW - 1));

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DD    = 2'd2
  } eq_state_t;

  // PAM2 reference levels, one bit wider than a sample so the error fits
  localparam logic signed [W:0] PAM_POS = (W + 1)'(1 << DATA_F);
  localparam logic signed [W:0] PAM_NEG = -PAM_POS;

  function automatic logic signed [W-1:0] sat_w(input logic signed [31:0] v);
    if (v > W_MAX) return W'(W_MAX);
    if (v < W_MIN) return W'(W_MIN);
    return W'(v);
  endfunction

  function automatic logic signed [CW-1:0] sat_cw(input logic signed [31:0] v);
    if (v > CW_MAX) return CW'(CW_MAX);
    if (v < CW_MIN) return CW'(CW_MIN);
    return CW'(v);
  endfunction

endpackage

// File: rtl/rx_lms_equalizer_tap.sv
// rtl/rx_lms_equalizer_tap.sv - one LMS coefficient register with saturating update
module lms_tap
  import rx_eq_pkg::*;
#(
  parameter logic signed [CW-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [W:0]    e,
  input  logic signed [W-1:0]  x,
  output logic signed [CW-1:0] coef
);

  localparam int PW = 2 * W + 1;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] step;
  logic signed [PW:0]   sum;

  // full-width error*sample product, floored by the step-size shift, added without wrap
  always_comb begin
    prod = $signed({{(PW - W - 1){e[W]}}, e}) * $signed({{(PW - W){x[W-1]}}, x});
    step = prod >>> UPD_SHIFT;
    sum  = {{(PW + 1 - CW){coef[CW-1]}}, coef} + {step[PW-1], step};
  end

  // coefficient register: reset to its initial tap value, clamp on update
  always_ff @(posedge clk) begin
    if (rst) begin
      coef <= RESET_VAL;
    end else if (en) begin
      coef <= sat_cw(32'(sum));
    end
  end

endmodule

// File: rtl/rx_lms_equalizer.sv
// rtl/rx_lms_equalizer.sv - adaptive symbol-rate FIR equalizer with training and decision-directed LMS
module rx_lms_equalizer
  import rx_eq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic signed [W-1:0] din,
  input  logic                train_bit,
  input  logic                start,
  input  logic                freeze,
  output logic                out_valid,
  output logic signed [W-1:0] dout,
  output logic                dec_bit,
  output logic signed [W:0]   err,
  output logic [1:0]          state
);

  localparam int PW = W + CW;

  eq_state_t               st;
  logic [CNT_W-1:0]        cnt;
  logic signed [W-1:0]     x [H];
  logic [CENTER:0]         ref_d;
  logic                    pend;
  logic signed [CW-1:0]    coef [H];
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [W-1:0]     y;
  logic signed [W:0]       ref_lvl;
  logic signed [W:0]       e;
  logic                    upd_en;

  assign state = st;

  // sample and training-bit delay lines advance once per accepted symbol
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < H; k++) x[k] <= '0;
      ref_d <= '0;
      pend  <= 1'b0;
    end else begin
      pend <= in_valid;
      if (in_valid) begin
        x[0] <= din;
        for (int k = 1; k < H; k++) x[k] <= x[k-1];
        ref_d <= {ref_d[CENTER-1:0], train_bit};
      end
    end
  end

  // FIR sum, output saturation, reference selection and error
  always_comb begin
    prod = '0;
    acc  = '0;
    for (int k = 0; k < H; k++) begin
      prod = $signed({{(PW - CW){coef[k][CW-1]}}, coef[k]}) * $signed({{(PW - W){x[k][W-1]}}, x[k]});
      acc  = acc + $signed({{(ACC_W - PW){prod[PW-1]}}, prod});
    end
    y = sat_w(32'(acc >>> COEF_F));
    if (st == ST_TRAIN) ref_lvl = ref_d[CENTER] ? PAM_POS : PAM_NEG;
    else                ref_lvl = y[W-1] ? PAM_NEG : PAM_POS;
    e      = ref_lvl - {y[W-1], y};
    upd_en = pend && (st != ST_IDLE) && !freeze;
  end

  // registered outputs: one pulse per accepted symbol, values held between pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
      dec_bit   <= 1'b0;
      err       <= '0;
    end else begin
      out_valid <= pend;
      if (pend) begin
        dout    <= y;
        dec_bit <= ~y[W-1];
        err     <= e;
      end
    end
  end

  // mode FSM: training length counts accepted symbols only, start always restarts training
  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= ST_IDLE;
      cnt <= '0;
    end else if (start) begin
      st  <= ST_TRAIN;
      cnt <= in_valid ? CNT_W'(1) : '0;
    end else if (st == ST_TRAIN && in_valid) begin
      if (cnt == CNT_W'(TRAIN_LEN - 1)) st <= ST_DD;
      else                              cnt <= cnt + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < H; k++) begin : g_tap
    lms_tap #(
      .RESET_VAL(CW'((k == CENTER) ? (1 << COEF_F) : 0))
    ) u_tap (
      .clk (clk),
      .rst (rst),
      .en  (upd_en),
      .e   (e),
      .x   (x[k]),
      .coef(coef[k])
    );
  end

endmodule

// File: tb/tb_rx_lms_equalizer.sv
// tb/tb_rx_lms_equalizer.sv - randomized self-checking bench for rx_lms_equalizer against a behavioural model
module tb_rx_lms_equalizer;
  import rx_eq_pkg::*;

  logic                clk = 1'b0;
  logic                rst, in_valid, train_bit, start, freeze;
  logic signed [W-1:0] din;
  logic                out_valid;
  logic signed [W-1:0] dout;
  logic                dec_bit;
  logic signed [W:0]   err;
  logic [1:0]          state;

  always #5 clk = ~clk;

  rx_lms_equalizer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .train_bit(train_bit),
    .start(start), .freeze(freeze), .out_valid(out_valid), .dout(dout),
    .dec_bit(dec_bit), .err(err), .state(state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // behavioural model: symbol history, tap values, mode, symbols trained so far
  int mx [H];
  int mc [H];
  int mst, mcnt;
  bit mpend;
  bit mtq[$];
  int e_ov, e_dout, e_dec, e_err;

  int q_dout[$];
  int q_dec[$];
  int q_err[$];

  logic [6:0] lfsr = 7'h7f;

  function automatic bit prbs_next();
    bit nb;
    nb   = lfsr[6] ^ lfsr[5];
    lfsr = {lfsr[5:0], nb};
    return nb;
  endfunction

  function automatic int sat(input int v, input int lo, input int hi);
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < H; k++) begin
      mx[k] = 0;
      mc[k] = (k == CENTER) ? 1024 : 0;
    end
    mst = 0; mcnt = 0; mpend = 0;
    mtq.delete();
    e_ov = 0; e_dout = 0; e_dec = 0; e_err = 0;
  endfunction

  function automatic void model_edge(input bit iv, input int d, input bit tbit, input bit st, input bit frz);
    int acc, y, rf, e, idx;
    bit rb;
    e_ov = mpend;
    if (mpend) begin
      acc = 0;
      for (int k = 0; k < H; k++) acc += mc[k] * mx[k];
      y   = sat(acc >>> 10, -256, 255);
      idx = mtq.size() - 1 - CENTER;
      rb  = (idx >= 0) ? mtq[idx] : 1'b0;
      if (mst == 1) rf = rb ? 128 : -128;
      else          rf = (y >= 0) ? 128 : -128;
      e = rf - y;
      e_dout = y; e_dec = (y >= 0); e_err = e;
      if (mst != 0 && !frz)
        for (int k = 0; k < H; k++) mc[k] = sat(mc[k] + ((e * mx[k]) >>> 8), -2048, 2047);
    end
    mpend = iv;
    if (iv) begin
      for (int k = H - 1; k > 0; k--) mx[k] = mx[k-1];
      mx[0] = d;
      mtq.push_back(tbit);
    end
    if (st) begin
      mst = 1; mcnt = iv ? 1 : 0;
    end else if (mst == 1 && iv) begin
      if (mcnt == TRAIN_LEN - 1) mst = 2;
      else mcnt++;
    end
  endfunction

  task automatic step(input bit iv, input int d, input bit tbit, input bit st, input bit frz, input bit r);
    rst = r; in_valid = iv; din = W'(d); train_bit = tbit; start = st; freeze = frz;
    if (r) model_reset();
    else   model_edge(iv, d, tbit, st, frz);
    @(posedge clk);
    #1;
    check("out_valid", out_valid, e_ov);
    check("state", state, mst);
    if (e_ov) begin
      check("dout", dout, e_dout);
      check("dec_bit", dec_bit, e_dec);
      check("err", err, e_err);
    end
    for (int k = 0; k < H; k++) check($sformatf("coef%0d", k), dut.coef[k], mc[k]);
    if (out_valid) begin
      q_dout.push_back(int'(dout));
      q_dec.push_back(int'(dec_bit));
      q_err.push_back(int'(err));
    end
  endtask

  function automatic void clear_q();
    q_dout.delete(); q_dec.delete(); q_err.delete();
  endfunction

  function automatic int rnd_din();
    return int'($urandom_range(0, 511)) - 256;
  endfunction

  int  snap [H];
  int  prev_s, s, d, seen;
  bit  b;
  bit  sent[$];

  initial begin
    rst = 1'b1; in_valid = 1'b0; din = '0; train_bit = 1'b0; start = 1'b0; freeze = 1'b0;
    model_reset();
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    check("rst_out_valid", out_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_state", state, 0);
    check("rst_c_center", dut.coef[CENTER], 1024);
    check("rst_c_edge", dut.coef[0], 0);

    // IDLE impulse response
    clear_q();
    step(1, 64, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("impulse_count", q_dout.size(), 8);
    for (int i = 0; i < 8 && i < q_dout.size(); i++) check("impulse_dout", q_dout[i], (i == CENTER) ? 64 : 0);
    check("impulse_c_center", dut.coef[CENTER], 1024);

    // training on PRBS7 through 1 + 0.5z^-1
    step(0, 0, 0, 1, 0, 0);
    check("start_to_train", state, 1);
    clear_q();
    sent.delete();
    prev_s = 0;
    for (int n = 0; n < TRAIN_LEN; n++) begin
      b = prbs_next();
      s = b ? 128 : -128;
      d = s + (prev_s >>> 1);
      prev_s = s;
      sent.push_back(b);
      step(1, d, b, 0, 0, 0);
      if (n == TRAIN_LEN - 2) check("train_state_before_end", state, 1);
      if (n == TRAIN_LEN - 1) check("train_to_dd", state, 2);
    end
    step(0, 0, 0, 0, 0, 0);
    check("train_out_count", q_dec.size(), TRAIN_LEN);
    for (int i = TRAIN_LEN - 64; i < TRAIN_LEN && i < q_dec.size(); i++) begin
      check("train_dec_vs_sent", q_dec[i], sent[i-CENTER]);
      check("train_err_small", (q_err[i] <= 32 && q_err[i] >= -32), 1);
    end

    // training with gaps: strobe every third cycle
    step(0, 0, 0, 1, 0, 0);
    for (int n = 0; n < TRAIN_LEN; n++) begin
      step(1, rnd_din(), 1'($urandom_range(0, 1)), 0, 0, 0);
      if (n == TRAIN_LEN - 2) check("gap_state_before_end", state, 1);
      if (n == TRAIN_LEN - 1) check("gap_to_dd", state, 2);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
    end
    for (int k = 0; k < H; k++) snap[k] = mc[k];
    step(0, 0, 0, 1, 0, 0);
    check("restart_from_dd", state, 1);
    for (int k = 0; k < H; k++) check("restart_coef_kept", dut.coef[k], snap[k]);

    // freeze during training: taps hold, outputs keep coming
    for (int k = 0; k < H; k++) snap[k] = mc[k];
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'($urandom_range(0, 1)), rnd_din(), 1'($urandom_range(0, 1)), 0, 1, 0);
      if (out_valid) seen++;
    end
    step(0, 0, 0, 0, 1, 0);
    check("freeze_outputs_seen", seen > 0, 1);
    for (int k = 0; k < H; k++) check("freeze_coef_const", dut.coef[k], snap[k]);

    // random mix of strobes, starts and freeze
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), rnd_din(), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0), 0);

    // saturation drives, then reset with a symbol in flight
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 255, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, -256, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 255, 1, 0, 0, 0);
    step(1, 100, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_state", state, 0);
    check("midrst_c_center", dut.coef[CENTER], 1024);
    step(0, 0, 0, 0, 0, 0);
    check("midrst_no_late_out", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
